div_iter: RTL
=============

Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the EX stage.
- Successor to the fixed 32-bit divider: operand width is a parameter, operands are captured once at start, divide-by-zero and signed-overflow results are defined, and an optional early-exit path is available.
- Returns {remainder, quotient}, which maps to {HI, LO}.
- Driven by the EX stall/start handshake: EX holds start_i high and stalls until ready_o.

Parameters:
- WIDTH, 32, operand width in bits (legal 8..64).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort the current operation (flush).
- signed_div_i  in  1  1 = signed, 0 = unsigned; sampled with start_i in IDLE.
- opdata1_i  in  WIDTH  dividend; sampled in IDLE.
- opdata2_i  in  WIDTH  divisor; sampled in IDLE.
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; registered.
- ready_o  out  1  result valid; registered.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0.
  - Reset in mid-operation discards all work; no stale ready.
- States and transitions:
  - IDLE, DIVZERO, ON, END.
  - IDLE:
    - start_i=1, annul_i=0, divisor==0 -> DIVZERO.
    - start_i=1, annul_i=0, divisor!=0 -> ON. Latch |dividend| and |divisor|; latch quotient sign = signed & (sign1 ^ sign2); latch remainder sign = signed & sign1. Counter=0.
    - Otherwise stay in IDLE.
  - ON:
    - One iteration per cycle: shift {rem, quo} left by 1; trial-subtract divisor from the upper part; on non-negative result keep the difference and set quo bit 0 = 1.
    - After WIDTH iterations (counter==WIDTH-1) -> END. On that edge load result_o with sign-corrected values and set ready_o=1.
  - DIVZERO:
    - -> END next cycle with quotient = all ones, remainder = raw opdata1 (unsigned and signed alike); ready_o=1.
  - END:
    - result_o and ready_o hold while start_i=1.
    - start_i=0 -> IDLE, ready_o=0, result_o=0.
- Latency: ready_o rises WIDTH+1 cycles after the edge that sampled start_i in IDLE (33 for WIDTH=32); 2 cycles for DIVZERO.
- Sign correction:
  - Quotient negated (two's complement) if its latched sign is 1; remainder likewise.
  - Signed MIN / -1 -> quotient = MIN (wraps), remainder = 0. No trap.
- Operand changes while busy are ignored; only the IDLE sample counts.
- annul_i:
  - In any state other than IDLE: -> IDLE next edge, ready_o=0, result_o=0.
  - Annul has priority over start_i and over completion on the same edge.
  - In IDLE it blocks acceptance of start_i.
- A new start is accepted only from IDLE, so back-to-back operations need start_i to drop for at least one cycle.

Optional Feature:
- DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if divisor!=0 and |dividend| < |divisor| -> END directly.
  - Quotient = 0, remainder = opdata1 unchanged (sign preserved); ready_o after 2 cycles.
  - All other cases unchanged.
- Undefined: every non-zero-divisor operation takes WIDTH+1 cycles; no magnitude comparator is synthesised.

Decomposition:
- Package div_pkg:
  - state typedef (IDLE=2'b00, DIVZERO=2'b01, ON=2'b10, END=2'b11).
  - DivStart/DivStop and DivResultReady/DivResultNotReady constants shared with EX.
- Optional sub-module div_step: one combinational restoring iteration, parametrised on WIDTH (inputs rem, quo, divisor; outputs next rem, next quo). The FSM, counter and sign logic stay in div_iter.

Test Plan:
- Unsigned 100/7, WIDTH=32, start held -> ready_o at cycle 33; result_o = {32'd2, 32'd14}. Drop start_i -> ready_o=0 next cycle.
- Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide-by-zero 0x12345678/0 -> ready_o at cycle 2; result_o = {0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000} after 33 cycles.
- annul_i pulse at iteration 10 -> IDLE next cycle, ready_o never rises. Fresh start 9/3 -> {0, 3}. Async rst asserted mid-ON -> all outputs 0 immediately.
- WIDTH=8, unsigned 200/13 -> {8'd5, 8'd15} after 9 cycles. With DIV_EARLY_EXIT_EN, 3/200 -> {8'd3, 8'd0} after 2 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared state encoding and EX handshake constants for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DIVZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } div_state_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // rem < divisor holds between iterations, so one extra bit is enough and
    // the top bit of the difference is a clean borrow flag.
    assign w_trial = {rem_i, quo_i[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, div_i};
    assign w_fits  = ~w_diff[WIDTH];

    assign rem_o = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN: skip iterations when |dividend| < |divisor|.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    div_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_div;
    logic                r_qsign;
    logic                r_rsign;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_ready;

    div_state_t          w_state_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [WIDTH-1:0]    w_rem_next;
    logic [WIDTH-1:0]    w_quo_next;
    logic [WIDTH-1:0]    w_div_next;
    logic                w_qsign_next;
    logic                w_rsign_next;
    logic [2*WIDTH-1:0]  w_result_next;
    logic                w_ready_next;

    logic                w_sign1;
    logic                w_sign2;
    logic [WIDTH-1:0]    w_abs1;
    logic [WIDTH-1:0]    w_abs2;
    logic [WIDTH-1:0]    w_step_rem;
    logic [WIDTH-1:0]    w_step_quo;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;

    assign w_sign1 = signed_div_i & opdata1_i[WIDTH-1];
    assign w_sign2 = signed_div_i & opdata2_i[WIDTH-1];
    assign w_abs1  = w_sign1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign w_abs2  = w_sign2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (r_rem),
        .quo_i (r_quo),
        .div_i (r_div),
        .rem_o (w_step_rem),
        .quo_o (w_step_quo)
    );

    // MIN / -1 falls out naturally: |MIN| is MIN as unsigned and signs cancel.
    assign w_quo_fix = r_qsign ? (~w_step_quo + WIDTH'(1)) : w_step_quo;
    assign w_rem_fix = r_rsign ? (~w_step_rem + WIDTH'(1)) : w_step_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_rem    <= w_rem_next;
            r_quo    <= w_quo_next;
            r_div    <= w_div_next;
            r_qsign  <= w_qsign_next;
            r_rsign  <= w_rsign_next;
            r_result <= w_result_next;
            r_ready  <= w_ready_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_rem_next    = r_rem;
        w_quo_next    = r_quo;
        w_div_next    = r_div;
        w_qsign_next  = r_qsign;
        w_rsign_next  = r_rsign;
        w_result_next = r_result;
        w_ready_next  = r_ready;

        case (r_state)
            IDLE: begin
                if (start_i == DivStart && !annul_i) begin
                    // DIVZERO doubles as the one-cycle hop for any result known
                    // at sample time; r_rem/r_quo hold the final pair.
                    if (opdata2_i == '0) begin
                        w_state_next = DIVZERO;
                        w_rem_next   = opdata1_i;
                        w_quo_next   = '1;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (w_abs1 < w_abs2) begin
                        w_state_next = DIVZERO;
                        w_rem_next   = opdata1_i;
                        w_quo_next   = '0;
                    end
`endif
                    else begin
                        w_state_next = ON;
                        w_cnt_next   = '0;
                        w_rem_next   = '0;
                        w_quo_next   = w_abs1;
                        w_div_next   = w_abs2;
                        w_qsign_next = w_sign1 ^ w_sign2;
                        w_rsign_next = w_sign1;
                    end
                end
            end
            DIVZERO: begin
                if (annul_i) begin
                    w_state_next  = IDLE;
                    w_result_next = '0;
                    w_ready_next  = DivResultNotReady;
                end else begin
                    w_state_next  = END;
                    w_result_next = {r_rem, r_quo};
                    w_ready_next  = DivResultReady;
                end
            end
            ON: begin
                if (annul_i) begin
                    w_state_next  = IDLE;
                    w_result_next = '0;
                    w_ready_next  = DivResultNotReady;
                end else begin
                    w_rem_next = w_step_rem;
                    w_quo_next = w_step_quo;
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_next  = END;
                        w_result_next = {w_rem_fix, w_quo_fix};
                        w_ready_next  = DivResultReady;
                    end
                end
            end
            END: begin
                if (annul_i || start_i == DivStop) begin
                    w_state_next  = IDLE;
                    w_result_next = '0;
                    w_ready_next  = DivResultNotReady;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state != IDLE);

endmodule
